// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU operation encodings and FSM state type
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - fixed-latency multiply/divide unit with HI/LO registers
// Results are computed at launch, held in p_hi/p_lo, and committed when the counter expires.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    mdu_state_e     state;
    mdu_state_e     next_state;
    logic [CW-1:0]  count;
    logic [31:0]    p_hi;
    logic [31:0]    p_lo;

    logic           is_mul;
    logic           is_div;
    logic           is_signed;
    logic [63:0]    a_ext;
    logic [63:0]    b_ext;
    logic [63:0]    product;
    logic [31:0]    a_mag;
    logic [31:0]    b_mag;
    logic [31:0]    b_safe;
    logic [31:0]    q_mag;
    logic [31:0]    r_mag;
    logic [31:0]    quot;
    logic [31:0]    rem;

    always_comb begin
        is_mul    = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
        is_div    = (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);
        is_signed = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);
    end

    // Low 64 bits of a 64x64 product are correct for both signed and unsigned extension.
    always_comb begin
        a_ext   = {{32{is_signed & A[31]}}, A};
        b_ext   = {{32{is_signed & B[31]}}, B};
        product = a_ext * b_ext;
    end

    // Signed divide on magnitudes; quotient sign from XOR of signs, remainder follows dividend.
    always_comb begin
        a_mag  = (is_signed && A[31]) ? -A : A;
        b_mag  = (is_signed && B[31]) ? -B : B;
        b_safe = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (is_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
        rem    = (is_signed && A[31]) ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && (is_mul || is_div)) next_state = BUSY;
            BUSY: if (count == CW'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else if (state == BUSY) begin
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                HI <= p_hi;
                LO <= p_lo;
            end
        end else if (start) begin
            case (MDUOp)
                MDU_MULT, MDU_MULTU: begin
                    p_hi  <= product[63:32];
                    p_lo  <= product[31:0];
                    count <= CW'(MULT_CYCLES);
                end
                MDU_DIV, MDU_DIVU: begin
                    // Divide by zero commits the current HI/LO, leaving them unchanged.
                    p_hi  <= (B == 32'd0) ? HI : rem;
                    p_lo  <= (B == 32'd0) ? LO : quot;
                    count <= CW'(DIV_CYCLES);
                end
                MDU_MTHI: HI <= A;
                MDU_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  MDUOp = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural HI/LO, pending result and cycles remaining.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    int          m_left = 0;

    task automatic model_launch();
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = $signed(A);
        sb = $signed(B);
        ua = A;
        ub = B;
        case (MDUOp)
            3'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5; end
            3'd2: begin pu = ua * ub; m_phi = pu[63:32]; m_plo = pu[31:0]; m_left = 5; end
            3'd3: begin
                if (B != 0) begin p = sa % sb; m_phi = p[31:0]; p = sa / sb; m_plo = p[31:0]; end
                else begin m_phi = m_hi; m_plo = m_lo; end
                m_left = 10;
            end
            3'd4: begin
                if (B != 0) begin pu = ua % ub; m_phi = pu[31:0]; pu = ua / ub; m_plo = pu[31:0]; end
                else begin m_phi = m_hi; m_plo = m_lo; end
                m_left = 10;
            end
            3'd5: m_hi = A;
            3'd6: m_lo = A;
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            model_launch();
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cyc_busy", busy, m_left > 0);
            check("cyc_hi", HI, m_hi);
            check("cyc_lo", LO, m_lo);
        end
    end

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk);
        #2;
        start = 1'b0; MDUOp = 3'd0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        launch(op, a, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) return;
            n++;
        end
        check("busy_timeout", busy, 0);
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_n,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        wait_idle(n);
        check({name, "_cycles"}, n, exp_n);
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        @(posedge clk);
        #2 reset = 1'b1;

        run("mult_neg",   3'd1, 32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB);
        run("multu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        run("div_neg",    3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run("divu",       3'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14);
        run("mthi",       3'd5, 32'h1234,     32'd0,        0,  32'h1234,     32'd14);
        run("mtlo",       3'd6, 32'h5678,     32'd0,        0,  32'h1234,     32'h5678);
        run("divu_zero",  3'd4, 32'd100,      32'd0,        10, 32'h1234,     32'h5678);
        run("div_zero",   3'd3, 32'hFFFFFFFB, 32'd0,        10, 32'h1234,     32'h5678);
        run("none",       3'd0, 32'd55,       32'd66,       0,  32'h1234,     32'h5678);
        run("reserved",   3'd7, 32'd55,       32'd66,       0,  32'h1234,     32'h5678);

        // A start in busy cycle 2 must be dropped.
        issue(3'd1, 32'd2, 32'd3);
        @(posedge clk);
        #2;
        launch(3'd3, 32'd9, 32'd3);
        wait_idle(n);
        check("ignore_cycles", n, 3);
        check("ignore_hi", HI, 0);
        check("ignore_lo", LO, 6);

        // Start in the first non-busy cycle is accepted.
        launch(3'd3, 32'd9, 32'd3);
        wait_idle(n);
        check("b2b_cycles", n, 10);
        check("b2b_hi", HI, 0);
        check("b2b_lo", LO, 3);

        // Reset during cycle 4 of a divide aborts it.
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_late_busy", busy, 0);
        check("abort_late_hi", HI, 0);
        check("abort_late_lo", LO, 0);

        run("mult_post", 3'd1, 32'h10000, 32'h10000, 5, 32'd1, 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
